// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM state encoding and ASCII constants for the Morse
// symbol decoder and its pattern lookup table.
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_GAP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_COLLECT    = 2'd1,
    S_AFTER_CHAR = 2'd2,
    S_OVERFLOW   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

endpackage

// File: rtl/morse_lut.sv
// Combinational International Morse lookup: element i of the pattern sits at
// pat[i] (dash=1, dot=0); unmapped (len,pat) pairs report hit=0.
module morse_lut (
  input  logic [2:0] len,
  input  logic [4:0] pat,
  output logic [7:0] ascii,
  output logic       hit
);
  import morse_pkg::*;

  always_comb begin
    ascii = ASCII_QMARK;
    hit   = 1'b1;
    unique case (len)
      3'd1: case (pat)
        5'd0: ascii = "E";  5'd1: ascii = "T";
        default: hit = 1'b0;
      endcase
      3'd2: case (pat)
        5'd0: ascii = "I";  5'd2: ascii = "A";
        5'd1: ascii = "N";  5'd3: ascii = "M";
        default: hit = 1'b0;
      endcase
      3'd3: case (pat)
        5'd0: ascii = "S";  5'd4: ascii = "U";
        5'd2: ascii = "R";  5'd6: ascii = "W";
        5'd1: ascii = "D";  5'd5: ascii = "K";
        5'd3: ascii = "G";  5'd7: ascii = "O";
        default: hit = 1'b0;
      endcase
      3'd4: case (pat)
        5'd0:  ascii = "H";  5'd8:  ascii = "V";
        5'd4:  ascii = "F";  5'd2:  ascii = "L";
        5'd6:  ascii = "P";  5'd14: ascii = "J";
        5'd1:  ascii = "B";  5'd9:  ascii = "X";
        5'd5:  ascii = "C";  5'd13: ascii = "Y";
        5'd3:  ascii = "Z";  5'd11: ascii = "Q";
        default: hit = 1'b0;
      endcase
      3'd5: case (pat)
        5'd31: ascii = "0";  5'd30: ascii = "1";
        5'd28: ascii = "2";  5'd24: ascii = "3";
        5'd16: ascii = "4";  5'd0:  ascii = "5";
        5'd1:  ascii = "6";  5'd3:  ascii = "7";
        5'd7:  ascii = "8";  5'd15: ascii = "9";
        default: hit = 1'b0;
      endcase
      default: hit = 1'b0;
    endcase
    if (!hit) ascii = ASCII_QMARK;
  end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Collects dot/dash symbols until a gap, translates the pattern to ASCII and
// offers it on a single-entry valid/ready output register.
module morse_symbol_decoder #(
  parameter int         MAX_LEN    = 5,
  parameter logic [7:0] ERR_CHAR   = 8'h3F,
  parameter logic [7:0] SPACE_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym_in,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       overrun
);
  import morse_pkg::*;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [4:0] pat_q, pat_d;
  logic [7:0] data_q;
  logic       valid_q, busy_q, overrun_q;

  logic       emit;
  logic [7:0] emit_char;
  logic [7:0] lut_ascii;
  logic       lut_hit;
  logic       elem;

  morse_lut u_lut (
    .len   (count_q),
    .pat   (pat_q),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );

  assign elem = (sym_in == SYM_DASH);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pat_d     = pat_q;
    emit      = 1'b0;
    emit_char = ERR_CHAR;
    unique case (sym_in)
      SYM_DOT, SYM_DASH: begin
        unique case (state_q)
          S_IDLE, S_AFTER_CHAR: begin
            pat_d    = {4'b0, elem};
            count_d  = 3'd1;
            state_d  = S_COLLECT;
          end
          S_COLLECT: begin
            if (count_q < 3'(MAX_LEN)) begin
              pat_d[count_q] = elem;
              count_d        = count_q + 3'd1;
            end else begin
              state_d = S_OVERFLOW;
            end
          end
          default: ;
        endcase
      end
      SYM_GAP: begin
        unique case (state_q)
          S_COLLECT, S_OVERFLOW: begin
            emit      = 1'b1;
            emit_char = (state_q == S_COLLECT && lut_hit) ? lut_ascii : ERR_CHAR;
            count_d   = 3'd0;
            pat_d     = 5'd0;
            state_d   = S_AFTER_CHAR;
          end
          S_AFTER_CHAR: begin
            emit      = 1'b1;
            emit_char = SPACE_CHAR;
            state_d   = S_IDLE;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Stage boundary: state, pattern buffer and single-entry output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= 3'd0;
      pat_q     <= 5'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pat_q   <= pat_d;
      busy_q  <= (state_d == S_COLLECT) || (state_d == S_OVERFLOW);
      // A handshake on the same edge frees the slot for the new character.
      if (emit && (!valid_q || char_ready)) begin
        valid_q <= 1'b1;
        data_q  <= emit_char;
      end else begin
        if (emit) overrun_q <= 1'b1;
        if (valid_q && char_ready) valid_q <= 1'b0;
      end
    end
  end

  assign char_data  = data_q;
  assign char_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed table-driven bench for morse_symbol_decoder with a few hand-written
// multi-cycle sequences.
module tb_morse_symbol_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] sym_in;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  morse_symbol_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] sym;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [1:0] sym, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic eb,
                     input logic eo);
    vec_t v;
    v.rst = rst; v.sym = sym; v.rdy = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb; v.exp_ovr = eo;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic [1:0] sym, input logic rdy);
    @(negedge clk);
    reset = rst; sym_in = sym; char_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, " char_valid"}, {7'b0, char_valid}, {7'b0, v.exp_valid});
    chk({tag, " busy"},       {7'b0, busy},       {7'b0, v.exp_busy});
    chk({tag, " overrun"},    {7'b0, overrun},    {7'b0, v.exp_ovr});
    if (v.exp_valid) chk({tag, " char_data"}, char_data, v.exp_data);
  endtask

  initial begin
    reset = 1'b1; sym_in = 2'b00; char_ready = 1'b1;

    // rst sym rdy | valid data busy ovr
    add(1, 2'b00, 1, 0, 8'h00, 0, 0);
    // 'A' then a space, then a repeated gap yields nothing
    add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b10, 1, 0, 8'h00, 1, 0);
    add(0, 2'b11, 1, 1, 8'h41, 0, 0);
    add(0, 2'b11, 1, 1, 8'h20, 0, 0);
    add(0, 2'b11, 1, 0, 8'h00, 0, 0);
    // 'B' with idle cycles interleaved
    add(0, 2'b10, 1, 0, 8'h00, 1, 0);
    add(0, 2'b00, 1, 0, 8'h00, 1, 0);
    add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b00, 1, 0, 8'h00, 1, 0);
    add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b00, 1, 0, 8'h00, 1, 0);
    add(0, 2'b11, 1, 1, 8'h42, 0, 0);
    add(0, 2'b00, 1, 0, 8'h00, 0, 0);
    // '0' (five dashes), then a word space
    for (int i = 0; i < 5; i++) add(0, 2'b10, 1, 0, 8'h00, 1, 0);
    add(0, 2'b11, 1, 1, 8'h30, 0, 0);
    add(0, 2'b11, 1, 1, 8'h20, 0, 0);
    add(0, 2'b00, 1, 0, 8'h00, 0, 0);
    // six dots overflow to '?'
    for (int i = 0; i < 6; i++) add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b00, 1, 0, 8'h00, 1, 0);
    add(0, 2'b11, 1, 1, 8'h3F, 0, 0);
    add(0, 2'b00, 1, 0, 8'h00, 0, 0);
    // unmapped length-4 pattern ..--
    add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b10, 1, 0, 8'h00, 1, 0);
    add(0, 2'b10, 1, 0, 8'h00, 1, 0);
    add(0, 2'b11, 1, 1, 8'h3F, 0, 0);
    add(0, 2'b00, 1, 0, 8'h00, 0, 0);
    // backpressure: 'E' held, 'T' dropped, overrun sticks
    add(0, 2'b01, 0, 0, 8'h00, 1, 0);
    add(0, 2'b11, 0, 1, 8'h45, 0, 0);
    add(0, 2'b10, 0, 1, 8'h45, 1, 0);
    add(0, 2'b11, 0, 1, 8'h45, 0, 1);
    add(0, 2'b00, 0, 1, 8'h45, 0, 1);
    add(0, 2'b00, 1, 0, 8'h00, 0, 1);
    // reset mid-collection discards buffered dashes
    add(0, 2'b10, 1, 0, 8'h00, 1, 1);
    add(0, 2'b10, 1, 0, 8'h00, 1, 1);
    add(1, 2'b00, 1, 0, 8'h00, 0, 0);
    add(0, 2'b01, 1, 0, 8'h00, 1, 0);
    add(0, 2'b11, 1, 1, 8'h45, 0, 0);
    add(0, 2'b00, 1, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].sym, vecs[i].rdy);
      chk_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // reset wins over a concurrent symbol; char_data clears
    step(1'b1, 2'b01, 1'b1);
    chk("rst char_data", char_data, 8'h00);
    chk("rst busy", {7'b0, busy}, 8'h00);
    // gap in idle after reset emits nothing
    step(1'b0, 2'b11, 1'b1);
    chk("idle gap valid", {7'b0, char_valid}, 8'h00);

    // 'K' (-.-) with a bounded wait for the character
    step(1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b01, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    begin
      int n;
      n = 0;
      while (!char_valid && n < 8) begin
        step(1'b0, 2'b00, 1'b0);
        n++;
      end
      chk("K timeout", {7'b0, char_valid}, 8'h01);
      chk("K data", char_data, 8'h4B);
      // held under backpressure across idle cycles
      step(1'b0, 2'b00, 1'b0);
      chk("K hold", char_data, 8'h4B);
      chk("K hold valid", {7'b0, char_valid}, 8'h01);
      step(1'b0, 2'b00, 1'b1);
      chk("K accepted", {7'b0, char_valid}, 8'h00);
      chk("K no overrun", {7'b0, overrun}, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
